// File: rtl/mpu_matrix_loader.sv
// Streams signed 8-bit elements into a packed 5x5 matrix of programmable order (1..5).
// Optional column-major loading is enabled by defining MPU_LOADER_TRANSPOSE_EN.
module mpu_matrix_loader (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic signed [7:0] size,
`ifdef MPU_LOADER_TRANSPOSE_EN
  input  logic              col_major,
`endif
  input  logic              in_valid,
  input  logic signed [7:0] in_data,
  output logic              in_ready,
  output logic [0:199]      matrix,
  output logic signed [7:0] out_size,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] row;
  logic [2:0] col;
  logic [2:0] dim;
  logic [7:0] cells [25];
  logic [4:0] wr_idx;
  logic       size_ok;
  logic       start_ok;
  logic       start_bad;
  logic       accept;
  logic       last;
  logic       transpose;

  assign size_ok   = (size > 8'sd0) && (size <= 8'sd5);
  assign start_ok  = (state == IDLE) && start && size_ok;
  assign start_bad = (state == IDLE) && start && !size_ok;
  assign accept    = (state == LOAD) && in_valid;
  assign last      = (row == dim - 3'd1) && (col == dim - 3'd1);

`ifdef MPU_LOADER_TRANSPOSE_EN
  logic col_major_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      col_major_q <= 1'b0;
    end else if (start_ok) begin
      col_major_q <= col_major;
    end
  end

  assign transpose = col_major_q;
`else
  assign transpose = 1'b0;
`endif

  // Column-major streams land at (col,row) so the stored layout is always row-major.
  always_comb begin
    wr_idx = 5'(row) * 5'd5 + 5'(col);
    if (transpose) begin
      wr_idx = 5'(col) * 5'd5 + 5'(row);
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      row      <= 3'd0;
      col      <= 3'd0;
      dim      <= 3'd0;
      out_size <= 8'sd0;
      error    <= 1'b0;
      for (int i = 0; i < 25; i++) begin
        cells[i] <= 8'd0;
      end
    end else begin
      state <= state_next;
      error <= start_bad;
      if (start_ok) begin
        dim      <= size[2:0];
        out_size <= size;
        row      <= 3'd0;
        col      <= 3'd0;
        for (int i = 0; i < 25; i++) begin
          cells[i] <= 8'd0;
        end
      end else if (accept) begin
        cells[wr_idx] <= in_data;
        if (col == dim - 3'd1) begin
          col <= 3'd0;
          row <= row + 3'd1;
        end else begin
          col <= col + 3'd1;
        end
      end
    end
  end

  always_comb begin
    matrix = '0;
    for (int i = 0; i < 25; i++) begin
      matrix[8*i +: 8] = cells[i];
    end
  end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Randomized self-checking bench for mpu_matrix_loader against a queue/array model.
// Transpose scenarios run only when MPU_LOADER_TRANSPOSE_EN is defined.
module tb_mpu_matrix_loader;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic signed [7:0] size = 8'sd0;
  logic              col_major = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_data = 8'sd0;
  logic              in_ready;
  logic [0:199]      matrix;
  logic signed [7:0] out_size;
  logic              busy;
  logic              done;
  logic              error;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_cells [25];
  int         exp_size = 0;
  logic [7:0] stream [25];

  always #5 clock = ~clock;

  mpu_matrix_loader dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .size     (size),
`ifdef MPU_LOADER_TRANSPOSE_EN
    .col_major(col_major),
`endif
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .matrix   (matrix),
    .out_size (out_size),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [0:199] expected_matrix();
    logic [0:199] m;
    m = '0;
    for (int i = 0; i < 25; i++) m[8*i +: 8] = exp_cells[i];
    return m;
  endfunction

  // Element k of an n*n stream belongs at row k/n, column k%n (swapped for column-major).
  task automatic model_load(input int n, input bit cm);
    int r;
    int c;
    for (int i = 0; i < 25; i++) exp_cells[i] = 8'h00;
    for (int k = 0; k < n * n; k++) begin
      r = k / n;
      c = k % n;
      if (cm) exp_cells[c * 5 + r] = stream[k];
      else    exp_cells[r * 5 + c] = stream[k];
    end
    exp_size = n;
  endtask

  task automatic check_matrix(input string name);
    logic [0:199] m;
    m = expected_matrix();
    tests_run++;
    if (matrix !== m) begin
      tests_failed++;
      $display("[TB] FAIL %s matrix got %h expected %h", name, matrix, m);
    end
    tests_run++;
    if (out_size !== 8'(exp_size)) begin
      tests_failed++;
      $display("[TB] FAIL %s out_size got %0d expected %0d", name, out_size, exp_size);
    end
  endtask

  // Runs one complete load; gap_every>0 drops in_valid on every gap_every-th cycle.
  task automatic run_load(input string name, input int n, input int gap_every,
                          input bit cm, input bit hold_start);
    int accepted;
    int cyc;
    int done_seen;
    start     = 1'b1;
    size      = 8'(n);
    col_major = cm;
    step();
    if (!hold_start) start = 1'b0;
    else size = 8'sd3;
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s entry in_ready/busy/done got %b%b%b expected 110",
               name, in_ready, busy, done);
    end
    accepted  = 0;
    cyc       = 0;
    done_seen = 0;
    while (accepted < n * n && cyc < 200) begin
      cyc++;
      if (gap_every != 0 && cyc % gap_every == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = stream[accepted];
      end
      step();
      if (in_valid) accepted++;
      if (done === 1'b1) done_seen++;
      tests_run++;
      if (accepted == n * n) begin
        if (done !== 1'b1 || in_ready !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL %s last accept done/in_ready got %b%b expected 10",
                   name, done, in_ready);
        end
      end else if (done !== 1'b0 || in_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL %s mid-load done/in_ready got %b%b expected 01 (accepted %0d)",
                 name, done, in_ready, accepted);
      end
    end
    in_valid = 1'b0;
    model_load(n, cm);
    step();
    if (done === 1'b1) done_seen++;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || done_seen != 1) begin
      tests_failed++;
      $display("[TB] FAIL %s after done: done=%b busy=%b pulses=%0d expected 0 0 1",
               name, done, busy, done_seen);
    end
    check_matrix(name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    tests_run++;
    if (matrix !== '0 || out_size !== 8'sd0 || busy !== 1'b0 || done !== 1'b0 ||
        error !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset outputs busy=%b done=%b error=%b in_ready=%b out_size=%0d expected all 0",
               busy, done, error, in_ready, out_size);
    end
    for (int i = 0; i < 25; i++) exp_cells[i] = 8'h00;
    exp_size = 0;
    check_matrix("reset");
  endtask

  task automatic test_size2_fixed();
    for (int i = 0; i < 25; i++) stream[i] = 8'(i + 1);
    run_load("size2_fixed", 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random_loads();
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 25; i++) stream[i] = 8'($urandom);
      run_load("random_load", int'($urandom_range(1, 5)), int'($urandom_range(0, 4)), 1'b0, 1'b0);
    end
  endtask

  task automatic test_size5_gaps();
    for (int i = 0; i < 25; i++) stream[i] = 8'(i + 1);
    run_load("size5_gaps", 5, 3, 1'b0, 1'b0);
  endtask

  task automatic test_illegal_size();
    logic signed [7:0] bad [4];
    bad[0] = 8'sd6;
    bad[1] = 8'sd0;
    bad[2] = 8'($urandom_range(7, 127));
    bad[3] = 8'($urandom_range(128, 255));
    for (int k = 0; k < 4; k++) begin
      start    = 1'b1;
      size     = bad[k];
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
      start = 1'b0;
      tests_run++;
      if (error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL illegal_size %0d error/in_ready/busy got %b%b%b expected 100",
                 bad[k], error, in_ready, busy);
      end
      step();
      tests_run++;
      if (error !== 1'b0 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL illegal_size pulse width error/in_ready got %b%b expected 00",
                 error, in_ready);
      end
      in_valid = 1'b0;
    end
    check_matrix("illegal_size_hold");
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1;
    size  = 8'sd3;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_load busy/in_ready/done got %b%b%b expected 000",
               busy, in_ready, done);
    end
    for (int i = 0; i < 25; i++) exp_cells[i] = 8'h00;
    exp_size = 0;
    check_matrix("reset_mid_load");
    stream[0] = 8'h80;
    run_load("size1_min", 1, 0, 1'b0, 1'b0);
  endtask

  // Start stays high across the whole load; the restart must wait for IDLE.
  task automatic test_back_to_back();
    for (int i = 0; i < 25; i++) stream[i] = 8'($urandom);
    run_load("held_start", 2, 0, 1'b0, 1'b1);
    step();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || out_size !== 8'sd3 || matrix !== '0) begin
      tests_failed++;
      $display("[TB] FAIL restart busy/in_ready got %b%b out_size %0d expected 11 3 with cleared matrix",
               busy, in_ready, out_size);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

`ifdef MPU_LOADER_TRANSPOSE_EN
  task automatic test_transpose();
    for (int i = 0; i < 25; i++) stream[i] = 8'(i + 1);
    run_load("transpose_size2", 2, 0, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) stream[i] = 8'($urandom);
    run_load("transpose_random", int'($urandom_range(1, 5)), 2, 1'b1, 1'b0);
    col_major = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_size2_fixed();
    test_random_loads();
    test_size5_gaps();
    test_illegal_size();
    test_reset_mid_load();
    test_back_to_back();
`ifdef MPU_LOADER_TRANSPOSE_EN
    test_transpose();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
